// File: rtl/trace_monitor_pkg.sv
// Shared types for the trace monitor: FSM states, record kinds and the trace record layout.
package trace_monitor_pkg;

   // Widest PC/data path a record can carry; narrower XLEN values zero-extend into it.
   localparam int XLEN_MAX = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_FAULT = 2'd3
   } mon_state_e;

   typedef enum logic [1:0] {
      KIND_NONE = 2'd0,
      KIND_WB   = 2'd1,
      KIND_ST   = 2'd2,
      KIND_LD   = 2'd3
   } trc_kind_e;

   typedef struct packed {
      trc_kind_e             kind;
      logic [XLEN_MAX-1:0]   pc;
      logic [XLEN_MAX-1:0]   d0;
      logic [XLEN_MAX-1:0]   d1;
   } trc_rec_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead record buffer with valid/ready on both sides; output data reads as zero when empty.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] mem [DEPTH];

   assign count     = wr_ptr - rd_ptr;
   assign full      = (count == (AW+1)'(DEPTH));
   assign out_valid = (wr_ptr != rd_ptr);
   assign pop       = out_valid & out_ready;
   // A full buffer still accepts when the head leaves on the same edge.
   assign in_ready  = ~full | pop;
   assign push      = in_valid & in_ready;
   assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr[AW-1:0]] <= in_data;
   end

endmodule

// File: rtl/trace_monitor.sv
// Core execution trace monitor: run/stop FSM with timeout, halt and misalign detection,
// plus a per-cycle record mux feeding a show-ahead trace buffer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for en; counters hold
// ST_RUN   | counting cycles, watching pc, emitting one record per event
// ST_DONE  | stopped on halt or timeout; sticky until clr
// ST_FAULT | stopped on misaligned pc; sticky until clr
module trace_monitor
   import trace_monitor_pkg::*;
#(
   parameter int          XLEN        = 32,
   parameter int          DEPTH       = 16,
   parameter int unsigned MAX_CYCLES  = 2000,
   parameter int          HALT_REPEAT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            en,
   input  logic            clr,
   input  logic [XLEN-1:0] pc,
   input  logic [31:0]     instr,
   input  logic            reg_write,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            mem_write,
   input  logic            mem_read,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            trc_valid,
   input  logic            trc_ready,
   output logic [1:0]      trc_kind,
   output logic [XLEN-1:0] trc_pc,
   output logic [XLEN-1:0] trc_d0,
   output logic [XLEN-1:0] trc_d1,
   output logic [1:0]      state,
   output logic            timeout,
   output logic            halted,
   output logic            misalign,
   output logic [XLEN-1:0] fault_pc,
   output logic [31:0]     cycle_cnt,
   output logic [15:0]     drop_cnt
);

   localparam int REC_W = 2 + 3*XLEN;

   mon_state_e       state_q;
   mon_state_e       state_d;
   logic [31:0]      cyc_inc;
   logic [31:0]      rep_cnt;
   logic [31:0]      rep_inc;
   logic [XLEN-1:0]  prev_pc;
   logic             prev_valid;
   logic             run;
   logic             misal;
   logic             same_pc;
   logic             halt_hit;
   logic             tmo_hit;
   trc_rec_t         rec_d;
   logic             push_req;
   logic             fifo_in_ready;
   logic             fifo_full;
   logic             drop;
   logic [REC_W-1:0] fifo_in;
   logic [REC_W-1:0] fifo_out;

   assign run      = (state_q == ST_RUN);
   assign misal    = (pc[1:0] != 2'b00);
   assign cyc_inc  = cycle_cnt + 32'd1;
   assign tmo_hit  = (cyc_inc >= 32'(MAX_CYCLES));
   // prev_valid keeps the very first RUN cycle from matching a stale pc.
   assign same_pc  = prev_valid && (pc == prev_pc);
   assign rep_inc  = same_pc ? rep_cnt + 32'd1 : 32'd0;
   assign halt_hit = same_pc && (rep_inc >= 32'(HALT_REPEAT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en) state_d = ST_RUN;
         ST_RUN: begin
            if (misal)                   state_d = ST_FAULT;
            else if (halt_hit || tmo_hit) state_d = ST_DONE;
            else if (!en)                state_d = ST_IDLE;
         end
         ST_DONE:  state_d = ST_DONE;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
      if (clr) state_d = ST_IDLE;
   end

   always_comb begin
      rec_d    = '0;
      rec_d.pc = XLEN_MAX'(pc);
      if (mem_write) begin
         rec_d.kind = KIND_ST;
         rec_d.d0   = XLEN_MAX'(mem_addr);
         rec_d.d1   = XLEN_MAX'(mem_wdata);
      end else if (mem_read) begin
         rec_d.kind = KIND_LD;
         rec_d.d0   = XLEN_MAX'(mem_addr);
         rec_d.d1   = XLEN_MAX'(mem_rdata);
      end else if (reg_write && (rd != 5'd0)) begin
         rec_d.kind = KIND_WB;
         rec_d.d0   = XLEN_MAX'(rd);
         rec_d.d1   = XLEN_MAX'(wb_data);
      end
      // The faulting cycle never produces a record.
      push_req = run && !misal && !clr && (rec_d.kind != KIND_NONE);
   end

   assign state = state_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_cnt  <= '0;
         rep_cnt    <= '0;
         prev_pc    <= '0;
         prev_valid <= 1'b0;
         timeout    <= 1'b0;
         halted     <= 1'b0;
         misalign   <= 1'b0;
         fault_pc   <= '0;
      end else if (clr) begin
         cycle_cnt  <= '0;
         rep_cnt    <= '0;
         prev_pc    <= '0;
         prev_valid <= 1'b0;
         timeout    <= 1'b0;
         halted     <= 1'b0;
         misalign   <= 1'b0;
         fault_pc   <= '0;
      end else if (run) begin
         cycle_cnt  <= cyc_inc;
         rep_cnt    <= rep_inc;
         prev_pc    <= pc;
         prev_valid <= 1'b1;
         if (misal) begin
            misalign <= 1'b1;
            fault_pc <= pc;
         end else if (halt_hit) begin
            halted <= 1'b1;
         end else if (tmo_hit) begin
            timeout <= 1'b1;
         end
      end
   end

   assign drop = push_req & ~fifo_in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  drop_cnt <= '0;
      else if (clr)  drop_cnt <= '0;
      else if (drop) drop_cnt <= sat_inc16(drop_cnt);
   end

   assign fifo_in = {rec_d.kind, rec_d.pc[XLEN-1:0], rec_d.d0[XLEN-1:0], rec_d.d1[XLEN-1:0]};

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (clr),
      .in_valid  (push_req),
      .in_ready  (fifo_in_ready),
      .in_data   (fifo_in),
      .out_valid (trc_valid),
      .out_ready (trc_ready),
      .out_data  (fifo_out),
      .full      (fifo_full)
   );

   assign {trc_kind, trc_pc, trc_d0, trc_d1} = fifo_out;

   // Bits that are carried for width-independence but never reach an output.
   generate
      if (XLEN < XLEN_MAX) begin : g_rec_hi
         logic unused_rec_hi;
         assign unused_rec_hi = ^{rec_d.pc[XLEN_MAX-1:XLEN], rec_d.d0[XLEN_MAX-1:XLEN],
                                  rec_d.d1[XLEN_MAX-1:XLEN]};
      end
   endgenerate

   logic unused_misc;
   assign unused_misc = ^{instr, fifo_full};

endmodule

// File: tb/tb_trace_monitor.sv
// Directed bench: instance A (MAX_CYCLES=10) covers FSM/record/reset behaviour,
// instance B (default MAX_CYCLES) covers buffer overflow, drain order and pointer wrap.
module tb_trace_monitor;

   logic        clk;
   logic        reset_n;
   logic        en;
   logic        clr;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] wb_data;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        trc_ready;

   logic        a_valid, a_timeout, a_halted, a_misalign;
   logic [1:0]  a_kind, a_state;
   logic [31:0] a_pc, a_d0, a_d1, a_fault_pc, a_cycle_cnt;
   logic [15:0] a_drop_cnt;

   logic        b_valid, b_timeout, b_halted, b_misalign;
   logic [1:0]  b_kind, b_state;
   logic [31:0] b_pc, b_d0, b_d1, b_fault_pc, b_cycle_cnt;
   logic [15:0] b_drop_cnt;

   int vectors = 0;
   int miscompares = 0;

   trace_monitor #(.XLEN(32), .DEPTH(16), .MAX_CYCLES(10), .HALT_REPEAT(4)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .pc(pc), .instr(instr),
      .reg_write(reg_write), .rd(rd), .wb_data(wb_data), .mem_write(mem_write),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .trc_valid(a_valid), .trc_ready(trc_ready), .trc_kind(a_kind), .trc_pc(a_pc),
      .trc_d0(a_d0), .trc_d1(a_d1), .state(a_state), .timeout(a_timeout), .halted(a_halted),
      .misalign(a_misalign), .fault_pc(a_fault_pc), .cycle_cnt(a_cycle_cnt), .drop_cnt(a_drop_cnt)
   );

   trace_monitor #(.XLEN(32), .DEPTH(16), .HALT_REPEAT(4)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .pc(pc), .instr(instr),
      .reg_write(reg_write), .rd(rd), .wb_data(wb_data), .mem_write(mem_write),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .trc_valid(b_valid), .trc_ready(trc_ready), .trc_kind(b_kind), .trc_pc(b_pc),
      .trc_d0(b_d0), .trc_d1(b_d1), .state(b_state), .timeout(b_timeout), .halted(b_halted),
      .misalign(b_misalign), .fault_pc(b_fault_pc), .cycle_cnt(b_cycle_cnt), .drop_cnt(b_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      en  = 1'b0;
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   logic [31:0] halt_pcs [6];

   initial begin
      reset_n = 1'b0; en = 1'b0; clr = 1'b0; pc = '0; instr = 32'h0000_0013;
      reg_write = 1'b0; rd = '0; wb_data = '0; mem_write = 1'b0; mem_read = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_rdata = '0; trc_ready = 1'b1;
      halt_pcs = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};

      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("rst_state",    a_state,     2'd0);
      check("rst_valid",    a_valid,     1'b0);
      check("rst_cycle",    a_cycle_cnt, 32'd0);
      check("rst_drop",     a_drop_cnt,  16'd0);
      check("rst_fault_pc", a_fault_pc,  32'd0);
      check("rst_trc_pc",   a_pc,        32'd0);

      // Timeout after MAX_CYCLES RUN cycles, no records
      en = 1'b1;
      step();
      check("to_enter_run", a_state, 2'd1);
      check("to_cnt0",      a_cycle_cnt, 32'd0);
      for (int i = 0; i < 10; i++) begin
         pc = 32'(i * 4);
         step();
         if (i == 8) begin
            check("to_still_run", a_state, 2'd1);
            check("to_cnt9",      a_cycle_cnt, 32'd9);
         end
      end
      check("to_state_done", a_state,     2'd2);
      check("to_timeout",    a_timeout,   1'b1);
      check("to_halted",     a_halted,    1'b0);
      check("to_cnt10",      a_cycle_cnt, 32'd10);
      check("to_no_records", a_valid,     1'b0);
      en = 1'b0;
      step();
      check("done_sticky", a_state, 2'd2);
      do_clr();
      check("clr_state",   a_state,     2'd0);
      check("clr_cnt",     a_cycle_cnt, 32'd0);
      check("clr_timeout", a_timeout,   1'b0);

      // Halt on HALT_REPEAT-1 repeats
      en = 1'b1;
      step();
      for (int i = 0; i < 6; i++) begin
         pc = halt_pcs[i];
         step();
         if (i == 4) check("halt_not_yet", a_state, 2'd1);
      end
      check("halt_state",   a_state,     2'd2);
      check("halt_flag",    a_halted,    1'b1);
      check("halt_timeout", a_timeout,   1'b0);
      check("halt_cnt",     a_cycle_cnt, 32'd6);
      do_clr();
      check("halt_clr", a_halted, 1'b0);

      // Misaligned pc: FAULT, fault_pc captured, no record on fault cycle
      en = 1'b1; trc_ready = 1'b0;
      step();
      pc = 32'h0; reg_write = 1'b1; rd = 5'd3; wb_data = 32'h55;
      step();
      check("wb_valid", a_valid, 1'b1);
      check("wb_kind",  a_kind,  2'd1);
      check("wb_pc",    a_pc,    32'h0);
      check("wb_d0",    a_d0,    32'd3);
      check("wb_d1",    a_d1,    32'h55);
      pc = 32'h6; rd = 5'd7; wb_data = 32'h77;
      step();
      check("mis_state",    a_state,    2'd3);
      check("mis_flag",     a_misalign, 1'b1);
      check("mis_fault_pc", a_fault_pc, 32'h6);
      check("mis_halted",   a_halted,   1'b0);
      check("mis_head",     a_d1,       32'h55);
      reg_write = 1'b0; trc_ready = 1'b1;
      step();
      check("mis_no_rec",   a_valid, 1'b0);
      check("fault_sticky", a_state, 2'd3);
      do_clr();
      check("mis_clr_flag", a_misalign, 1'b0);
      check("mis_clr_pc",   a_fault_pc, 32'h0);

      // Record priority and stability under back-pressure
      en = 1'b1; trc_ready = 1'b0;
      step();
      pc = 32'h10; mem_read = 1'b1; mem_addr = 32'h100; mem_rdata = 32'hDEAD_BEEF;
      reg_write = 1'b1; rd = 5'd5; wb_data = 32'h99;
      step();
      check("ld_valid", a_valid, 1'b1);
      check("ld_kind",  a_kind,  2'd3);
      check("ld_pc",    a_pc,    32'h10);
      check("ld_d0",    a_d0,    32'h100);
      check("ld_d1",    a_d1,    32'hDEAD_BEEF);
      pc = 32'h14; mem_write = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h1234;
      step();
      check("ld_stable_kind", a_kind, 2'd3);
      check("ld_stable_d1",   a_d1,   32'hDEAD_BEEF);
      pc = 32'h18; mem_write = 1'b0; mem_read = 1'b0; rd = 5'd0; en = 1'b0; trc_ready = 1'b1;
      step();
      check("st_kind",  a_kind,  2'd2);
      check("st_pc",    a_pc,    32'h14);
      check("st_d0",    a_d0,    32'h200);
      check("st_d1",    a_d1,    32'h1234);
      check("to_idle",  a_state, 2'd0);
      reg_write = 1'b0;
      step();
      check("rd0_no_rec", a_valid,     1'b0);
      check("idle_hold",  a_cycle_cnt, 32'd3);
      do_clr();

      // Overflow on instance B: 20 WB records into 16 entries
      en = 1'b1; trc_ready = 1'b0;
      step();
      for (int i = 0; i < 20; i++) begin
         pc = 32'h1000 + 32'(i * 4); reg_write = 1'b1; rd = 5'(i + 1); wb_data = 32'hA0 + 32'(i);
         step();
      end
      check("ovf_drop",  b_drop_cnt,  16'd4);
      check("ovf_valid", b_valid,     1'b1);
      check("ovf_cnt",   b_cycle_cnt, 32'd20);
      check("ovf_state", b_state,     2'd1);
      en = 1'b0; reg_write = 1'b0;
      step();
      trc_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check("drain_valid", b_valid, 1'b1);
         check("drain_pc",    b_pc,    32'h1000 + 32'(i * 4));
         check("drain_d0",    b_d0,    32'(i + 1));
         check("drain_d1",    b_d1,    32'hA0 + 32'(i));
         step();
      end
      check("drain_empty", b_valid,    1'b0);
      check("drain_drop",  b_drop_cnt, 16'd4);
      en = 1'b1;
      step();
      pc = 32'h2000; reg_write = 1'b1; rd = 5'd9; wb_data = 32'hBB;
      step();
      reg_write = 1'b0;
      check("wrap_valid", b_valid, 1'b1);
      check("wrap_d1",    b_d1,    32'hBB);
      do_clr();
      check("clr_drop", b_drop_cnt, 16'd0);

      // Asynchronous reset mid-RUN with buffered records
      en = 1'b1; trc_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         pc = 32'h40 + 32'(i * 4); reg_write = 1'b1; rd = 5'd2; wb_data = 32'hC0 + 32'(i);
         step();
      end
      check("pre_rst_valid", a_valid,     1'b1);
      check("pre_rst_cnt",   a_cycle_cnt, 32'd5);
      #1 reset_n = 1'b0;
      #1;
      check("arst_state", a_state,     2'd0);
      check("arst_valid", a_valid,     1'b0);
      check("arst_pc",    a_pc,        32'd0);
      check("arst_d1",    a_d1,        32'd0);
      check("arst_cnt",   a_cycle_cnt, 32'd0);
      #2 reset_n = 1'b1;
      reg_write = 1'b0; pc = 32'h80;
      step();
      check("post_rst_run", a_state,     2'd1);
      check("post_rst_cnt", a_cycle_cnt, 32'd0);
      pc = 32'h84;
      step();
      check("post_rst_cnt1", a_cycle_cnt, 32'd1);
      check("post_rst_empty", a_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/trace_monitor.md
TRACE_MONITOR -- requirements
Module: trace_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning trace FIFO entries; the value SHALL be a power of 2 and at least 2.
REQ-003 SHALL have parameter MAX_CYCLES, default 2000, meaning RUN-cycle timeout limit (1..2^32-1).
REQ-004 SHALL have parameter HALT_REPEAT, default 4, meaning consecutive identical-PC cycles that declare halt (>=2).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  run enable.
REQ-008 clr  input  1  one-cycle clear request.
REQ-009 pc, instr  input  XLEN, 32  core fetch PC and instruction.
REQ-010 reg_write, rd, wb_data  input  1, 5, XLEN  register write-back strobe, destination, value.
REQ-011 mem_write, mem_read, mem_addr, mem_wdata, mem_rdata  input  1, 1, XLEN, XLEN, XLEN  data memory access.
REQ-012 trc_valid, trc_ready  output, input  1, 1  trace valid/ready handshake.
REQ-013 trc_kind, trc_pc, trc_d0, trc_d1  output  2, XLEN, XLEN, XLEN  trace record fields.
REQ-014 state, timeout, halted, misalign, fault_pc  output  2, 1, 1, 1, XLEN  status.
REQ-015 cycle_cnt, drop_cnt  output  32, 16  RUN-cycle count; dropped-record count.

Function
REQ-016 FSM SHALL have states IDLE=0, RUN=1, DONE=2, FAULT=3, exposed on state.
REQ-017 IDLE->RUN SHALL occur when en=1; RUN->IDLE SHALL occur when en=0, and all counters SHALL hold while in IDLE.
REQ-018 In RUN, cycle_cnt SHALL increment by 1 each cycle; when cycle_cnt reaches MAX_CYCLES, the next state SHALL be DONE with timeout=1.
REQ-019 In RUN, a repeat counter SHALL count cycles with pc equal to the previous cycle's pc; reaching HALT_REPEAT-1 repeats SHALL give next state DONE with halted=1.
REQ-020 In RUN, pc[1:0]!=0 SHALL give next state FAULT with misalign=1, and fault_pc SHALL capture that pc.
REQ-021 Same-cycle terminating conditions SHALL take priority misalign > halt > timeout, and only the winning flag SHALL be set.
REQ-022 DONE and FAULT SHALL be sticky and ignore en; clr=1 SHALL return to IDLE, clear flags/counters/fault_pc, and flush the FIFO.
REQ-023 clr in IDLE or RUN SHALL perform the same clear and leave the FSM in IDLE.
REQ-024 One record per RUN cycle SHALL be generated, with priority mem_write > mem_read > (reg_write & rd!=0).
REQ-025 ST record SHALL be kind=2, d0=mem_addr, d1=mem_wdata.
REQ-026 LD record SHALL be kind=3, d0=mem_addr, d1=mem_rdata.
REQ-027 WB record SHALL be kind=1, d0={rd zero-extended}, d1=wb_data.
REQ-028 trc_pc SHALL equal the pc of the generating cycle.
REQ-029 No record SHALL be generated in IDLE/DONE/FAULT, or on the cycle a FAULT is detected.
REQ-030 A record sampled at edge N SHALL be visible on trc_* after edge N (1-cycle latency, show-ahead FIFO).
REQ-031 Pop SHALL occur on trc_valid & trc_ready at the rising edge; trc_valid=0 when empty; trc_* SHALL be stable while trc_valid=1 and trc_ready=0.
REQ-032 Push when full SHALL be accepted only if a pop occurs the same cycle; otherwise the record is dropped and drop_cnt increments, saturating at 16'hFFFF.
REQ-033 Simultaneous push+pop when empty SHALL be equivalent to a push, and the FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-034 Draining SHALL remain permitted in every state.

Reset
REQ-035 reset_n=0 SHALL asynchronously force state=IDLE; timeout, halted, misalign, trc_valid=0; fault_pc, cycle_cnt, drop_cnt, repeat counter, and FIFO pointers=0; trc_kind/pc/d0/d1=0.
REQ-036 Reset mid-RUN SHALL discard all buffered records, and the first RUN cycle after release SHALL count as cycle_cnt=1.

Structure
REQ-037 Package trace_monitor_pkg SHALL hold the state enum, the kind enum (NONE=0, WB=1, ST=2, LD=3), and the trace record struct.
REQ-038 A sub-module trace_fifo (parameters WIDTH, DEPTH; valid/ready output, full flag) SHALL implement the buffer.
REQ-039 The top level SHALL contain the FSM, counters and record mux.

Verification
REQ-040 en=1 with pc stepping 0,4,8,..., no memory traffic, MAX_CYCLES=10 -> DONE after 10 RUN cycles, timeout=1, cycle_cnt=10, halted=0.
REQ-041 pc sequence 0,4,8,8,8,8 with HALT_REPEAT=4 -> DONE with halted=1 on the edge after the fourth 8.
REQ-042 pc=0x0000_0006 in RUN -> FAULT next cycle, misalign=1, fault_pc=0x6, and no record for that cycle.
REQ-043 Cycle with mem_read=1, addr=0x100, rdata=0xDEADBEEF, reg_write=1, rd=5 -> single record kind=3, d0=0x100, d1=0xDEADBEEF.
REQ-044 trc_ready=0 with DEPTH=16 and 20 WB records -> 16 buffered, drop_cnt=4; then trc_ready=1 -> 16 records popped in order, then trc_valid=0.
REQ-045 reset_n pulsed low for 3 ns mid-RUN with 5 records buffered (asynchronous, between edges) -> outputs zero immediately, trc_valid=0, state=IDLE.
